// File: rtl/uart_arb_defs.sv
// uart_arb_defs: shared definitions for the UART transmit arbiter.
//   arb_state_e      - arbiter FSM encodings (ST_IDLE / ST_HOLD / ST_WAIT)
//   DEF_HOLDOFF      - default cycles to ignore tx_ready after a write strobe
//   DEF_LOCK_TIMEOUT - default idle cycles before a stalled lock is dropped
package uart_arb_defs;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_WAIT = 2'd2
  } arb_state_e;

  localparam int DEF_HOLDOFF      = 2;
  localparam int DEF_LOCK_TIMEOUT = 1024;

endpackage

// File: rtl/uart_rr_picker.sv
// uart_rr_picker: combinational NREQ-way round-robin selector.
//   req [NREQ-1:0] - request vector
//   ptr [IDXW-1:0] - last served index; search starts at ptr+1 and wraps
//   hit            - at least one request set
//   idx [IDXW-1:0] - first set request at or after ptr+1 (mod NREQ)
module uart_rr_picker #(
  parameter int NREQ = 4,
  parameter int IDXW = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDXW-1:0] ptr,
  output logic            hit,
  output logic [IDXW-1:0] idx
);

  logic [IDXW-1:0] pos;

  // Scan from the farthest candidate back to the nearest so the nearest
  // set request after ptr is the one left in idx.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    pos = '0;
    for (int k = NREQ; k >= 1; k--) begin
      pos = IDXW'((int'(ptr) + k) % NREQ);
      if (req[pos]) begin
        hit = 1'b1;
        idx = pos;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UartTx between NREQ byte-stream requesters.
// Round-robin arbitration with packet locking: a winner keeps the
// transmitter until it sends a byte flagged last, or until it stalls for
// LOCK_TIMEOUT idle cycles.
//   CLK, RST          - clock, synchronous active-high reset
//   req_valid/last    - per-requester byte valid and end-of-packet flag
//   req_data          - packed bytes, requester i at [8i+7:8i]
//   req_ack           - one-cycle accept pulse to the winning requester
//   tx_data, tx_we    - byte and write strobe to UartTx
//   tx_ready          - UartTx idle
//   grant_valid/idx   - lock held / current or last owner
//   lock_drop         - one-cycle pulse when a lock is released by timeout
module uart_tx_arbiter
  import uart_arb_defs::*;
#(
  parameter int NREQ         = 4,
  parameter int IDXW         = 2,
  parameter int HOLDOFF      = DEF_HOLDOFF,
  parameter int LOCK_TIMEOUT = DEF_LOCK_TIMEOUT
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*8-1:0] req_data,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   req_ack,
  output logic [7:0]        tx_data,
  output logic              tx_we,
  input  logic              tx_ready,
  output logic              grant_valid,
  output logic [IDXW-1:0]   grant_idx,
  output logic              lock_drop
);

  localparam int TOW = (LOCK_TIMEOUT > 0) ? $clog2(LOCK_TIMEOUT + 1) : 1;
  localparam int HW  = $clog2(HOLDOFF + 1);

  arb_state_e      state_q, state_d;
  logic [HW-1:0]   hold_cnt_q, hold_cnt_d;
  logic [TOW-1:0]  to_cnt_q, to_cnt_d;
  logic [IDXW-1:0] ptr_q, ptr_d;
  logic            last_q, last_d;
  logic            grant_valid_q, grant_valid_d;
  logic [IDXW-1:0] grant_idx_q, grant_idx_d;
  logic [NREQ-1:0] req_ack_q, req_ack_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            tx_we_q, tx_we_d;
  logic            lock_drop_q, lock_drop_d;

  logic [NREQ-1:0] cand;
  logic            pick_hit;
  logic [IDXW-1:0] pick_idx;
  logic            issue;
  logic            timeout;

  // While locked only the owner may compete; a one-hot candidate vector
  // makes the picker return the owner regardless of ptr.
  always_comb begin
    cand = req_valid;
    if (grant_valid_q) begin
      cand = '0;
      cand[grant_idx_q] = req_valid[grant_idx_q];
    end
  end

  uart_rr_picker #(
    .NREQ (NREQ),
    .IDXW (IDXW)
  ) u_picker (
    .req (cand),
    .ptr (ptr_q),
    .hit (pick_hit),
    .idx (pick_idx)
  );

  assign issue = (state_q == ST_IDLE) && tx_ready && pick_hit;

  // State register
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q       <= ST_IDLE;
      hold_cnt_q    <= '0;
      to_cnt_q      <= '0;
      ptr_q         <= IDXW'(NREQ - 1);
      last_q        <= 1'b0;
      grant_valid_q <= 1'b0;
      grant_idx_q   <= '0;
      req_ack_q     <= '0;
      tx_data_q     <= '0;
      tx_we_q       <= 1'b0;
      lock_drop_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      hold_cnt_q    <= hold_cnt_d;
      to_cnt_q      <= to_cnt_d;
      ptr_q         <= ptr_d;
      last_q        <= last_d;
      grant_valid_q <= grant_valid_d;
      grant_idx_q   <= grant_idx_d;
      req_ack_q     <= req_ack_d;
      tx_data_q     <= tx_data_d;
      tx_we_q       <= tx_we_d;
      lock_drop_q   <= lock_drop_d;
    end
  end

  // Next-state: FSM, lock ownership, round-robin pointer, timeout
  always_comb begin
    state_d       = state_q;
    hold_cnt_d    = hold_cnt_q;
    to_cnt_d      = to_cnt_q;
    ptr_d         = ptr_q;
    last_d        = last_q;
    grant_valid_d = grant_valid_q;
    grant_idx_d   = grant_idx_q;
    timeout       = 1'b0;

    // The timeout counts only idle cycles where the owner has nothing to send.
    if (issue) begin
      to_cnt_d = '0;
    end else if ((LOCK_TIMEOUT != 0) && (state_q == ST_IDLE) && grant_valid_q &&
                 !req_valid[grant_idx_q]) begin
      if (to_cnt_q == TOW'(LOCK_TIMEOUT - 1)) begin
        timeout  = 1'b1;
        to_cnt_d = '0;
      end else begin
        to_cnt_d = to_cnt_q + 1'b1;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (issue) begin
          state_d       = ST_HOLD;
          hold_cnt_d    = '0;
          grant_valid_d = 1'b1;
          grant_idx_d   = pick_idx;
          last_d        = req_last[pick_idx];
        end else if (timeout) begin
          grant_valid_d = 1'b0;
          ptr_d         = grant_idx_q;
        end
      end
      // tx_ready may still read high for a few cycles after the strobe.
      ST_HOLD: begin
        if (hold_cnt_q == HW'(HOLDOFF - 1)) begin
          state_d = ST_WAIT;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      ST_WAIT: begin
        if (tx_ready) begin
          state_d = ST_IDLE;
          // End of packet: release, owner drops to lowest priority.
          if (last_q) begin
            grant_valid_d = 1'b0;
            ptr_d         = grant_idx_q;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs: strobes and the issued byte
  always_comb begin
    req_ack_d   = '0;
    tx_we_d     = 1'b0;
    tx_data_d   = tx_data_q;
    lock_drop_d = timeout;
    if (issue) begin
      req_ack_d[pick_idx] = 1'b1;
      tx_we_d             = 1'b1;
      tx_data_d           = req_data[pick_idx*8 +: 8];
    end
  end

  assign req_ack     = req_ack_q;
  assign tx_data     = tx_data_q;
  assign tx_we       = tx_we_q;
  assign grant_valid = grant_valid_q;
  assign grant_idx   = grant_idx_q;
  assign lock_drop   = lock_drop_q;

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares one UartTx instance between NREQ byte-stream requesters using round-robin arbitration with packet locking. Once a requester wins, it keeps the transmitter until it sends a byte flagged last, so packets are never interleaved on TXD. Sits between the client logic and UartTx. It drives UartTx's data/we inputs and observes its ready output.

Parameters:
NREQ, 4, number of requesters (2..8)
IDXW, 2, width of grant index (= clog2(NREQ))
HOLDOFF, 2, cycles after tx_we during which tx_ready is ignored (covers UartTx ready-drop latency); min 1
LOCK_TIMEOUT, 1024, idle cycles a locked owner may stall before its lock is forcibly dropped; 0 disables the timeout

Ports:
CLK  in  1  system clock
RST  in  1  reset; synchronous, active-high
req_valid  in  NREQ  per-requester byte valid; must be held with data stable until acked
req_data  in  NREQ*8  packed bytes; requester i occupies [8i+7:8i]
req_last  in  NREQ  byte is the final byte of the packet; sampled with data
req_ack  out  NREQ  one-cycle pulse: byte accepted; requester may change data next cycle
tx_data  out  8  byte to UartTx
tx_we  out  1  one-cycle write strobe to UartTx
tx_ready  in  1  UartTx idle/ready
grant_valid  out  1  a requester currently holds the lock
grant_idx  out  IDXW  current/last owner index
lock_drop  out  1  one-cycle pulse when a lock is released by timeout

Behaviour:
- Reset (sync, RST=1 at posedge):
  - All outputs 0: req_ack, tx_data, tx_we, grant_valid, grant_idx, lock_drop.
  - State IDLE; timeout counter 0; rr pointer = NREQ-1, so requester 0 has first priority.
- States: IDLE, HOLD, WAIT. All outputs are registered.
- IDLE, unlocked, tx_ready=1, any req_valid:
  - Winner = first set req_valid searching upward from (ptr+1) mod NREQ, with wrap.
  - Next cycle: tx_data=req_data[winner], tx_we=1, req_ack[winner]=1, grant_valid=1, grant_idx=winner; state -> HOLD.
  - Latency from req_valid sample to tx_we/ack: 1 cycle.
- IDLE, locked:
  - Only the owner is considered. Other requests wait, even if asserted.
  - Owner valid with tx_ready=1: issue as above.
- HOLD: tx_we=0, req_ack=0. Count HOLDOFF cycles, then -> WAIT.
- WAIT: stay until tx_ready=1, then -> IDLE.
  - If the issued byte had last=1: grant_valid->0 and ptr<=owner (owner gets lowest priority next round).
  - If last=0: lock is retained.
- Minimum spacing between tx_we pulses: HOLDOFF+2 cycles.
- tx_ready=0 in IDLE: no issue and no ack; requests stay pending.
- Timeout:
  - Counter increments each IDLE cycle while locked and the owner's req_valid=0; it clears on any issue.
  - When count reaches LOCK_TIMEOUT: grant_valid->0, ptr<=owner, lock_drop=1 for one cycle, counter->0.
  - Arbitration resumes the next IDLE cycle.
- Simultaneous requests: exactly one ack per issue; never two acks in one cycle.
- Owner deasserts req_valid mid-packet: lock held; timeout applies.
- req_valid dropped by a non-owner before ack: no effect (requesters must not do this; not checked).
- RST during HOLD/WAIT:
  - Returns to IDLE immediately; the byte in flight in UartTx completes on its own.
  - The arbiter still waits for tx_ready=1 before the next issue.
- A packet of one byte with last=1 locks and releases within the same transaction.

Decomposition:
- Shared header/package uart_arb_defs:
  - state encodings ST_IDLE/ST_HOLD/ST_WAIT;
  - default HOLDOFF and LOCK_TIMEOUT constants.
- One sub-module, uart_rr_picker: combinational NREQ-way round-robin selector.
  - Inputs: req vector, ptr.
  - Outputs: hit, idx.
  - Reused by future RX-side dispatch.
- Timeout counter width: clog2(LOCK_TIMEOUT+1).

Test Plan:
1. After reset, req0 and req2 valid, both last=1, tx_ready=1 → ack0/tx_we with tx_data=req0 byte first. ack2 follows only after HOLDOFF+tx_ready, then ptr=2.
2. req1 sends 3-byte packet 0x61,0x62,0x63 (last on 0x63) while req3 stays valid → tx_data sequence 61,62,63 uninterrupted, then req3 served. grant_idx=1 throughout the packet.
3. All four requesters continuously valid with last=1 → grant order 0,1,2,3,0,1; no two acks in any cycle; spacing ≥ HOLDOFF+2.
4. tx_ready held 0 for 500 cycles with req0 valid → no tx_we/ack. The first issue occurs 1 cycle after tx_ready rises.
5. req1 sends one byte with last=0, then drops valid; LOCK_TIMEOUT=16 → lock_drop pulses after 16 idle cycles, grant_valid=0. Pending req2 is issued next.
6. RST asserted in WAIT → all outputs 0 next cycle. After release with tx_ready=0, no issue until tx_ready=1; the first grant goes to the lowest pending index.
